// File: rtl/reli_rx_seq_check_if.sv
// Handshake bundle between the receive parser/deparser/control path and the
// receive sequence checker.
//   meta    : s_meta_flow, s_meta_rpn, s_meta_rst, s_meta_ack_req,
//             s_meta_valid -> checker, s_meta_ready <- checker
//   verdict : m_verdict_code, m_verdict_pass, m_verdict_valid <- checker,
//             m_verdict_ready -> checker
//   feedback: m_fb_flow, m_fb_rpn, m_fb_type, m_fb_valid <- checker,
//             m_fb_ready -> checker
// The master modport is the environment side, the slave modport is the checker.
interface reli_rx_seq_check_if #(
  parameter int FLOW_IDX_WIDTH = 10,
  parameter int RPN_WIDTH      = 32
);
  logic [FLOW_IDX_WIDTH-1:0] s_meta_flow;
  logic [RPN_WIDTH-1:0]      s_meta_rpn;
  logic                      s_meta_rst;
  logic                      s_meta_ack_req;
  logic                      s_meta_valid;
  logic                      s_meta_ready;

  logic [1:0]                m_verdict_code;
  logic                      m_verdict_pass;
  logic                      m_verdict_valid;
  logic                      m_verdict_ready;

  logic [FLOW_IDX_WIDTH-1:0] m_fb_flow;
  logic [RPN_WIDTH-1:0]      m_fb_rpn;
  logic                      m_fb_type;
  logic                      m_fb_valid;
  logic                      m_fb_ready;

  modport master (
    output s_meta_flow, s_meta_rpn, s_meta_rst, s_meta_ack_req, s_meta_valid,
    input  s_meta_ready,
    input  m_verdict_code, m_verdict_pass, m_verdict_valid,
    output m_verdict_ready,
    input  m_fb_flow, m_fb_rpn, m_fb_type, m_fb_valid,
    output m_fb_ready
  );

  modport slave (
    input  s_meta_flow, s_meta_rpn, s_meta_rst, s_meta_ack_req, s_meta_valid,
    output s_meta_ready,
    output m_verdict_code, m_verdict_pass, m_verdict_valid,
    input  m_verdict_ready,
    output m_fb_flow, m_fb_rpn, m_fb_type, m_fb_valid,
    input  m_fb_ready
  );
endinterface

// File: rtl/reli_rx_seq_check.sv
// Receive-side sequence checker. Keeps a per-flow {nak_sent, expected RPN}
// table, returns accept/duplicate/gap verdicts and requests ACK/NAK feedback.
//   clk_i             : clock
//   rst_i             : synchronous active-high reset, restarts table init
//   reliable_enbale_i : 0 = bypass (accept all, no table update, no feedback)
//   bus               : meta in, verdict out, feedback out (slave modport)
//   stat_*_o          : wrapping accept/duplicate/gap event counters
//
// state | meaning
// INIT  | clearing table entries 0..FLOW_COUNT-1, one per cycle
// IDLE  | ready for metadata; handshake launches the table read
// RD    | table read data arriving
// EVAL  | classify packet, update table, register verdict/feedback
// OUT   | present verdict (and feedback), wait for both handshakes
module reli_rx_seq_check #(
  parameter int FLOW_COUNT     = 1024,
  parameter int FLOW_IDX_WIDTH = $clog2(FLOW_COUNT),
  parameter int RPN_WIDTH      = 32,
  parameter int ACK_SHIFT      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reliable_enbale_i,
  reli_rx_seq_check_if.slave      bus,
  output logic [31:0]             stat_accept_o,
  output logic [31:0]             stat_dup_o,
  output logic [31:0]             stat_gap_o
);
  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [1:0] V_ACCEPT = 2'd0;
  localparam logic [1:0] V_DUP    = 2'd1;
  localparam logic [1:0] V_GAP    = 2'd2;

  localparam logic [FLOW_IDX_WIDTH-1:0] LAST_FLOW = FLOW_IDX_WIDTH'(FLOW_COUNT - 1);
  localparam logic [FLOW_IDX_WIDTH-1:0] FLOW_ONE  = FLOW_IDX_WIDTH'(1);
  localparam logic [RPN_WIDTH-1:0]      RPN_ONE   = RPN_WIDTH'(1);

  logic [2:0]                state_q, state_d;
  logic [FLOW_IDX_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [FLOW_IDX_WIDTH-1:0] flow_q, flow_d;
  logic [RPN_WIDTH-1:0]      rpn_q, rpn_d;
  logic                      rstf_q, rstf_d;
  logic                      ack_req_q, ack_req_d;
  logic                      bypass_q, bypass_d;
  logic [1:0]                code_q, code_d;
  logic                      pass_q, pass_d;
  logic                      vvalid_q, vvalid_d;
  logic [FLOW_IDX_WIDTH-1:0] fb_flow_q, fb_flow_d;
  logic [RPN_WIDTH-1:0]      fb_rpn_q, fb_rpn_d;
  logic                      fb_type_q, fb_type_d;
  logic                      fvalid_q, fvalid_d;
  logic [31:0]               st_acc_q, st_acc_d;
  logic [31:0]               st_dup_q, st_dup_d;
  logic [31:0]               st_gap_q, st_gap_d;

  // Flow table: single-port RAM, one-cycle registered read.
  logic [RPN_WIDTH:0]        ram_q [FLOW_COUNT];
  logic [RPN_WIDTH:0]        ram_rdata_q;
  logic                      ram_we, ram_re;
  logic [FLOW_IDX_WIDTH-1:0] ram_addr;
  logic [RPN_WIDTH:0]        ram_wdata;

  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata_q <= ram_q[ram_addr];
  end

  logic [RPN_WIDTH-1:0] exp_rd, diff, rpn_inc;
  logic                 nak_rd;

  assign exp_rd  = ram_rdata_q[RPN_WIDTH-1:0];
  assign nak_rd  = ram_rdata_q[RPN_WIDTH];
  assign diff    = rpn_q - exp_rd;
  assign rpn_inc = rpn_q + RPN_ONE;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    flow_d     = flow_q;
    rpn_d      = rpn_q;
    rstf_d     = rstf_q;
    ack_req_d  = ack_req_q;
    bypass_d   = bypass_q;
    code_d     = code_q;
    pass_d     = pass_q;
    vvalid_d   = vvalid_q;
    fb_flow_d  = fb_flow_q;
    fb_rpn_d   = fb_rpn_q;
    fb_type_d  = fb_type_q;
    fvalid_d   = fvalid_q;
    st_acc_d   = st_acc_q;
    st_dup_d   = st_dup_q;
    st_gap_d   = st_gap_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = flow_q;
    ram_wdata  = '0;

    case (state_q)
      S_INIT: begin
        ram_we     = 1'b1;
        ram_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + FLOW_ONE;
        if (init_cnt_q == LAST_FLOW) state_d = S_IDLE;
      end
      S_IDLE: begin
        ram_addr = bus.s_meta_flow;
        if (bus.s_meta_valid) begin
          ram_re    = 1'b1;
          flow_d    = bus.s_meta_flow;
          rpn_d     = bus.s_meta_rpn;
          rstf_d    = bus.s_meta_rst;
          ack_req_d = bus.s_meta_ack_req;
          bypass_d  = ~reliable_enbale_i;
          state_d   = S_RD;
        end
      end
      S_RD: state_d = S_EVAL;
      S_EVAL: begin
        vvalid_d  = 1'b1;
        fvalid_d  = 1'b0;
        fb_flow_d = flow_q;
        state_d   = S_OUT;
        if (bypass_q) begin
          code_d   = V_ACCEPT;
          pass_d   = 1'b1;
          st_acc_d = st_acc_q + 32'd1;
        end else if (rstf_q || diff == '0) begin
          code_d    = V_ACCEPT;
          pass_d    = 1'b1;
          st_acc_d  = st_acc_q + 32'd1;
          ram_we    = 1'b1;
          ram_wdata = {1'b0, rpn_inc};
          fb_type_d = 1'b0;
          fb_rpn_d  = rpn_inc;
          fvalid_d  = rstf_q | ack_req_q | (rpn_inc[ACK_SHIFT-1:0] == '0);
        end else if (diff[RPN_WIDTH-1]) begin
          // Negative distance: already received; re-ACK the cumulative point.
          code_d    = V_DUP;
          pass_d    = 1'b0;
          st_dup_d  = st_dup_q + 32'd1;
          fb_type_d = 1'b0;
          fb_rpn_d  = exp_rd;
          fvalid_d  = 1'b1;
        end else begin
          // Gap: NAK only once per loss episode; nak_sent clears on next accept.
          code_d   = V_GAP;
          pass_d   = 1'b0;
          st_gap_d = st_gap_q + 32'd1;
          if (!nak_rd) begin
            fb_type_d = 1'b1;
            fb_rpn_d  = exp_rd;
            fvalid_d  = 1'b1;
            ram_we    = 1'b1;
            ram_wdata = {1'b1, exp_rd};
          end
        end
      end
      S_OUT: begin
        vvalid_d = vvalid_q & ~bus.m_verdict_ready;
        fvalid_d = fvalid_q & ~bus.m_fb_ready;
        if (!vvalid_d && !fvalid_d) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      flow_q     <= '0;
      rpn_q      <= '0;
      rstf_q     <= 1'b0;
      ack_req_q  <= 1'b0;
      bypass_q   <= 1'b0;
      code_q     <= V_ACCEPT;
      pass_q     <= 1'b0;
      vvalid_q   <= 1'b0;
      fb_flow_q  <= '0;
      fb_rpn_q   <= '0;
      fb_type_q  <= 1'b0;
      fvalid_q   <= 1'b0;
      st_acc_q   <= '0;
      st_dup_q   <= '0;
      st_gap_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      flow_q     <= flow_d;
      rpn_q      <= rpn_d;
      rstf_q     <= rstf_d;
      ack_req_q  <= ack_req_d;
      bypass_q   <= bypass_d;
      code_q     <= code_d;
      pass_q     <= pass_d;
      vvalid_q   <= vvalid_d;
      fb_flow_q  <= fb_flow_d;
      fb_rpn_q   <= fb_rpn_d;
      fb_type_q  <= fb_type_d;
      fvalid_q   <= fvalid_d;
      st_acc_q   <= st_acc_d;
      st_dup_q   <= st_dup_d;
      st_gap_q   <= st_gap_d;
    end
  end

  assign bus.s_meta_ready    = (state_q == S_IDLE);
  assign bus.m_verdict_code  = code_q;
  assign bus.m_verdict_pass  = pass_q;
  assign bus.m_verdict_valid = vvalid_q;
  assign bus.m_fb_flow       = fb_flow_q;
  assign bus.m_fb_rpn        = fb_rpn_q;
  assign bus.m_fb_type       = fb_type_q;
  assign bus.m_fb_valid      = fvalid_q;
  assign stat_accept_o       = st_acc_q;
  assign stat_dup_o          = st_dup_q;
  assign stat_gap_o          = st_gap_q;
endmodule

// File: doc/reli_rx_seq_check.md
# reli_rx_seq_check

Receive-side sequence checker for the reliable transport. It is the peer of the reliable transmit pipeline, which stamps a per-flow packet sequence number (RPN) and a reset flag on every reliable packet. The block sits after the receive parser and keeps an expected-RPN table per flow. For every parsed packet it returns a pass/drop verdict to the receive deparser. It also emits ACK/NAK feedback requests toward the control path that builds acknowledgement packets.

## Interface
Parameters:
- FLOW_COUNT, 1024, number of flow table entries (power of two)
- FLOW_IDX_WIDTH, $clog2(FLOW_COUNT), flow index width
- RPN_WIDTH, 32, sequence number width
- ACK_SHIFT, 4, an ACK is emitted when (rpn+1) mod 2^ACK_SHIFT == 0

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- reliable_enbale  in  1  0 = bypass: every packet passes, table untouched, no feedback
- s_meta_flow  in  FLOW_IDX_WIDTH  flow index of the packet
- s_meta_rpn  in  RPN_WIDTH  packet sequence number
- s_meta_rst  in  1  sender reset flag: resynchronise the flow to this RPN
- s_meta_ack_req  in  1  sender requests an immediate ACK
- s_meta_valid / s_meta_ready  in/out  1  metadata handshake
- m_verdict_code  out  2  0 accept, 1 duplicate, 2 gap
- m_verdict_pass  out  1  1 only for accept
- m_verdict_valid / m_verdict_ready  out/in  1  verdict handshake
- m_fb_flow  out  FLOW_IDX_WIDTH  flow of the feedback
- m_fb_rpn  out  RPN_WIDTH  cumulative ACK or NAK sequence number (the next expected RPN)
- m_fb_type  out  1  0 ACK, 1 NAK
- m_fb_valid / m_fb_ready  out/in  1  feedback handshake
- stat_accept, stat_dup, stat_gap  out  32 each  event counters; they wrap

## Operation
- Table entry: {nak_sent(1), expected(RPN_WIDTH)}. Single-port synchronous RAM with 1-cycle read latency.
- FSM states: INIT, IDLE, RD, EVAL, OUT.
- INIT: writes 0 to entries 0..FLOW_COUNT-1, one per cycle, then goes to IDLE. s_meta_ready=0 during INIT.
- IDLE: s_meta_ready=1. On handshake, capture the metadata, issue a RAM read at s_meta_flow, and go to RD.
- RD: RAM data arrives. Go to EVAL.
- EVAL: compute diff = (rpn − expected) mod 2^RPN_WIDTH, then apply the first matching rule:
  - s_meta_rst=1: accept; write {0, rpn+1}.
  - diff==0: accept; write {0, rpn+1}.
  - diff[MSB]==1: duplicate; no table write; ACK with expected.
  - otherwise: gap; no expected update.
    - If nak_sent==0: NAK with expected; write {1, expected}.
    - If nak_sent==1: no feedback.
- ACK on accept: emitted if s_meta_ack_req=1, or s_meta_rst=1, or (rpn+1)[ACK_SHIFT-1:0]==0. The ACK carries rpn+1.
- Bypass (reliable_enbale=0, sampled at the IDLE handshake): the verdict is accept, no RAM write, no feedback. The bypass path still passes through RD and EVAL.
- The matching stat counter increments in EVAL, including in bypass (counts as accept).
- OUT: m_verdict_valid=1. m_fb_valid=1 if feedback was generated. Each valid drops independently on its own handshake. Go to IDLE once both are done.
- All RPN arithmetic is modulo 2^RPN_WIDTH. Wrap-around is handled by the diff sign rule: expected=0xFFFFFFFF with rpn=0x00000000 is a gap of 1, not a duplicate.

## Timing
- Reset values: s_meta_ready=0, m_verdict_valid=0, m_fb_valid=0, m_verdict_code=0, m_verdict_pass=0, m_fb_flow=0, m_fb_rpn=0, m_fb_type=0, all stat counters=0. The FSM enters INIT.
- First s_meta_ready=1 occurs FLOW_COUNT cycles after rst deasserts.
- Latency: a handshake in cycle T gives valid outputs in cycle T+3. The minimum period is 4 cycles per packet (IDLE, RD, EVAL, OUT).
- Outputs are registered and held stable while valid=1 and ready=0.
- Exactly one request is in flight, so back-to-back packets on the same flow need no forwarding.
- rst asserted in any state aborts the operation, clears all outputs to their reset values, and restarts INIT. A partly sent verdict or feedback is discarded.

## Test plan
- Reset, then flow 5 sends rpn 0,1,2: three accepts. ACK rpn=1 for rpn 0 only if s_meta_ack_req=1. Entry becomes expected=3. stat_accept=3.
- Flow 5 at expected=3 sends rpn 1: duplicate, pass=0, ACK rpn=3, stat_dup=1.
- Flow 5 at expected=3 sends rpn 6 then rpn 7: the first gives gap plus NAK rpn=3. The second gives gap with no feedback. Then rpn 3 is accepted and nak_sent clears.
- Flow 9 at expected=0xFFFFFFFF sends 0xFFFFFFFF then 0x00000000: two accepts, expected ends at 1. ACK rpn=0 is emitted because (0xFFFFFFFF+1)[3:0]==0.
- Hold m_fb_ready=0 for 10 cycles during a NAK: the verdict completes, fb stays valid and stable, and s_meta_ready stays 0 until the fb handshake.
- Assert rst in EVAL, then check all outputs are 0, s_meta_ready=0 for FLOW_COUNT cycles, and every flow reads expected=0 afterwards (rpn 0 is accepted).
